// File: rtl/parking_allocator.sv
// Spot allocator for a 32-spot lot: two entry gates and one exit gate share one
// sequential scanner that owns the occupancy map and the per-spot plate table.
module parking_allocator #(
  parameter int PLATE_W = 7,
  parameter int NSPOT   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         ent_req,
  input  logic [PLATE_W-1:0] ent_plate0,
  input  logic [PLATE_W-1:0] ent_plate1,
  output logic [1:0]         ent_ack,
  output logic               ent_ok,
  output logic               ent_dup,
  output logic [4:0]         ent_spot,
  input  logic               ext_req,
  input  logic [PLATE_W-1:0] ext_plate,
  output logic               ext_ack,
  output logic               ext_found,
  output logic [4:0]         ext_spot,
  output logic [7:0]         parq1_status,
  output logic [7:0]         parq2_status,
  output logic [7:0]         parq3_status,
  output logic [7:0]         parq4_status,
  output logic [5:0]         free_count,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SCAN_ENT, SCAN_EXT, DONE} state_t;

  state_t             state;
  logic [NSPOT-1:0]   occ;
  logic [PLATE_W-1:0] plate_tab [NSPOT];
  logic               rr;
  logic               gate;
  logic [4:0]         idx;
  logic [PLATE_W-1:0] lat_plate;
  logic               free_found;
  logic [4:0]         free_idx;
  logic               dup;

  logic       plate_hit;
  logic       free_now;
  logic [4:0] spot_now;
  logic       dup_now;
  logic       commit;
  logic       last;
  logic       grant_gate;

  // Current-cycle view of the scan folds in the spot under idx, so the final
  // visit (idx 31) can decide the outcome without an extra cycle.
  always_comb begin
    plate_hit  = occ[idx] && (plate_tab[idx] == lat_plate) && (lat_plate != '0);
    free_now   = free_found || !occ[idx];
    spot_now   = free_found ? free_idx : idx;
    dup_now    = dup || plate_hit;
    commit     = (lat_plate != '0) && !dup_now && free_now;
    last       = (idx == 5'(NSPOT - 1));
    grant_gate = ent_req[rr] ? rr : ~rr;
  end

  assign parq1_status = occ[7:0];
  assign parq2_status = occ[15:8];
  assign parq3_status = occ[23:16];
  assign parq4_status = occ[31:24];
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      occ        <= '0;
      for (int i = 0; i < NSPOT; i++) plate_tab[i] <= '0;
      rr         <= 1'b0;
      gate       <= 1'b0;
      idx        <= '0;
      lat_plate  <= '0;
      free_found <= 1'b0;
      free_idx   <= '0;
      dup        <= 1'b0;
      free_count <= 6'(NSPOT);
      ent_ack    <= '0;
      ent_ok     <= 1'b0;
      ent_dup    <= 1'b0;
      ent_spot   <= '0;
      ext_ack    <= 1'b0;
      ext_found  <= 1'b0;
      ext_spot   <= '0;
    end else begin
      ent_ack   <= '0;
      ent_ok    <= 1'b0;
      ent_dup   <= 1'b0;
      ent_spot  <= '0;
      ext_ack   <= 1'b0;
      ext_found <= 1'b0;
      ext_spot  <= '0;
      case (state)
        IDLE: begin
          if (ext_req) begin
            lat_plate <= ext_plate;
            idx       <= '0;
            state     <= SCAN_EXT;
          end else if (ent_req != 2'b00) begin
            gate       <= grant_gate;
            rr         <= ~grant_gate;
            lat_plate  <= grant_gate ? ent_plate1 : ent_plate0;
            idx        <= '0;
            free_found <= 1'b0;
            free_idx   <= '0;
            dup        <= 1'b0;
            state      <= SCAN_ENT;
          end
        end
        // Entry always walks all 32 spots so duplicates anywhere are caught.
        SCAN_ENT: begin
          free_found <= free_now;
          free_idx   <= spot_now;
          dup        <= dup_now;
          idx        <= idx + 5'd1;
          if (last) begin
            state   <= DONE;
            ent_ack <= gate ? 2'b10 : 2'b01;
            ent_dup <= dup_now;
            if (commit) begin
              ent_ok              <= 1'b1;
              ent_spot            <= spot_now;
              occ[spot_now]       <= 1'b1;
              plate_tab[spot_now] <= lat_plate;
              free_count          <= free_count - 6'd1;
            end
          end
        end
        SCAN_EXT: begin
          if (plate_hit) begin
            occ[idx]       <= 1'b0;
            plate_tab[idx] <= '0;
            free_count     <= free_count + 6'd1;
            ext_found      <= 1'b1;
            ext_spot       <= idx;
            ext_ack        <= 1'b1;
            state          <= DONE;
          end else if (last) begin
            ext_ack <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_allocator.sv
// Directed bench for parking_allocator: cycle-exact ack latency, arbitration,
// duplicate/invalid/full rejects, exit lookup and reset abort.
module tb_parking_allocator;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ent_req;
  logic [6:0] ent_plate0, ent_plate1;
  logic [1:0] ent_ack;
  logic       ent_ok, ent_dup;
  logic [4:0] ent_spot;
  logic       ext_req;
  logic [6:0] ext_plate;
  logic       ext_ack, ext_found;
  logic [4:0] ext_spot;
  logic [7:0] parq1_status, parq2_status, parq3_status, parq4_status;
  logic [5:0] free_count;
  logic       busy;

  int testsRun = 0;
  int testsFailed = 0;

  parking_allocator dut (
    .clk(clk), .reset(reset),
    .ent_req(ent_req), .ent_plate0(ent_plate0), .ent_plate1(ent_plate1),
    .ent_ack(ent_ack), .ent_ok(ent_ok), .ent_dup(ent_dup), .ent_spot(ent_spot),
    .ext_req(ext_req), .ext_plate(ext_plate),
    .ext_ack(ext_ack), .ext_found(ext_found), .ext_spot(ext_spot),
    .parq1_status(parq1_status), .parq2_status(parq2_status),
    .parq3_status(parq3_status), .parq4_status(parq4_status),
    .free_count(free_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] er, input logic [6:0] p0, input logic [6:0] p1,
                               input logic xr, input logic [6:0] xp);
    ent_req = er; ent_plate0 = p0; ent_plate1 = p1; ext_req = xr; ext_plate = xp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until any ack shows up, bounded so a dead DUT cannot hang the run.
  task automatic waitAck(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (ent_ack == 2'b00 && !ext_ack && cyc < 60);
  endtask

  task automatic doReset();
    applyStimulus(2'b00, 7'h0, 7'h0, 1'b0, 7'h0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic runEntry(input logic g, input logic [6:0] plate, input logic ok,
                          input logic dp, input logic [4:0] spot);
    int cyc;
    if (g) applyStimulus(2'b10, 7'h0, plate, 1'b0, 7'h0);
    else   applyStimulus(2'b01, plate, 7'h0, 1'b0, 7'h0);
    waitAck(cyc);
    checkOutput("ent_latency", cyc, 33);
    checkOutput("ent_ack", 32'(ent_ack), g ? 32'd2 : 32'd1);
    checkOutput("ent_ok", 32'(ent_ok), 32'(ok));
    checkOutput("ent_dup", 32'(ent_dup), 32'(dp));
    checkOutput("ent_spot", 32'(ent_spot), 32'(spot));
    applyStimulus(2'b00, 7'h0, 7'h0, 1'b0, 7'h0);
    step();
  endtask

  task automatic runExit(input logic [6:0] plate, input logic found, input logic [4:0] spot,
                         input int expCyc);
    int cyc;
    applyStimulus(2'b00, 7'h0, 7'h0, 1'b1, plate);
    waitAck(cyc);
    checkOutput("ext_latency", cyc, expCyc);
    checkOutput("ext_ack", 32'(ext_ack), 1);
    checkOutput("ext_found", 32'(ext_found), 32'(found));
    checkOutput("ext_spot", 32'(ext_spot), 32'(spot));
    applyStimulus(2'b00, 7'h0, 7'h0, 1'b0, 7'h0);
    step();
  endtask

  // Both gates request at once; the first winner drops, the loser stays held.
  task automatic runBoth(input logic [6:0] p0, input logic [6:0] p1, input logic firstGate,
                         input logic [4:0] firstSpot, input logic [4:0] secondSpot);
    int cyc;
    applyStimulus(2'b11, p0, p1, 1'b0, 7'h0);
    waitAck(cyc);
    checkOutput("both_first_latency", cyc, 33);
    checkOutput("both_first_ack", 32'(ent_ack), firstGate ? 32'd2 : 32'd1);
    checkOutput("both_first_spot", 32'(ent_spot), 32'(firstSpot));
    ent_req = firstGate ? 2'b01 : 2'b10;
    waitAck(cyc);
    checkOutput("both_second_gap", cyc, 34);
    checkOutput("both_second_ack", 32'(ent_ack), firstGate ? 32'd1 : 32'd2);
    checkOutput("both_second_ok", 32'(ent_ok), 1);
    checkOutput("both_second_spot", 32'(ent_spot), 32'(secondSpot));
    applyStimulus(2'b00, 7'h0, 7'h0, 1'b0, 7'h0);
    step();
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    applyStimulus(2'b00, 7'h0, 7'h0, 1'b0, 7'h0);
    doReset();
    checkOutput("rst_ent_ack", 32'(ent_ack), 0);
    checkOutput("rst_ext_ack", 32'(ext_ack), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_free", 32'(free_count), 32);
    checkOutput("rst_status", {parq4_status, parq3_status, parq2_status, parq1_status}, 0);

    runEntry(1'b0, 7'h4C, 1'b1, 1'b0, 5'd0);
    checkOutput("first_parq1", 32'(parq1_status), 32'h01);
    checkOutput("first_free", 32'(free_count), 31);
    runExit(7'h4C, 1'b1, 5'd0, 2);
    checkOutput("first_exit_free", 32'(free_count), 32);

    // Arbitration: rr starts at gate 0, a lone gate 0 entry moves it to gate 1.
    doReset();
    runBoth(7'h35, 7'h12, 1'b0, 5'd0, 5'd1);
    runEntry(1'b0, 7'h44, 1'b1, 1'b0, 5'd2);
    runBoth(7'h56, 7'h57, 1'b1, 5'd3, 5'd4);
    checkOutput("arb_parq1", 32'(parq1_status), 32'h1F);
    checkOutput("arb_free", 32'(free_count), 27);

    // Spots 0..8 hold plates 1..9, spot 9 holds 0x20.
    doReset();
    for (int s = 0; s < 9; s++) runEntry(1'b0, 7'(s + 1), 1'b1, 1'b0, 5'(s));
    runEntry(1'b1, 7'h20, 1'b1, 1'b0, 5'd9);
    checkOutput("pre_exit_parq2", 32'(parq2_status), 32'h03);
    runExit(7'h20, 1'b1, 5'd9, 11);
    checkOutput("exit_parq2", 32'(parq2_status), 32'h01);
    checkOutput("exit_free", 32'(free_count), 23);
    runEntry(1'b0, 7'h05, 1'b0, 1'b1, 5'd0);
    runEntry(1'b1, 7'h00, 1'b0, 1'b0, 5'd0);
    checkOutput("reject_parq1", 32'(parq1_status), 32'hFF);
    checkOutput("reject_parq2", 32'(parq2_status), 32'h01);
    checkOutput("reject_free", 32'(free_count), 23);
    runExit(7'h7F, 1'b0, 5'd0, 33);

    for (int s = 9; s < 32; s++) runEntry(1'b0, 7'(s + 1), 1'b1, 1'b0, 5'(s));
    checkOutput("full_status", {parq4_status, parq3_status, parq2_status, parq1_status}, 32'hFFFF_FFFF);
    checkOutput("full_free", 32'(free_count), 0);
    runEntry(1'b1, 7'h70, 1'b0, 1'b0, 5'd0);
    checkOutput("full_reject_free", 32'(free_count), 0);
    runExit(7'h06, 1'b1, 5'd5, 7);
    checkOutput("full_exit_free", 32'(free_count), 1);
    runEntry(1'b0, 7'h71, 1'b1, 1'b0, 5'd5);

    // Exit wins over a simultaneous entry; the entry follows right after DONE.
    applyStimulus(2'b01, 7'h72, 7'h0, 1'b1, 7'h71);
    waitAck(cyc);
    checkOutput("mix_ext_latency", cyc, 7);
    checkOutput("mix_ext_ack", 32'(ext_ack), 1);
    checkOutput("mix_ent_idle", 32'(ent_ack), 0);
    checkOutput("mix_ext_spot", 32'(ext_spot), 5);
    ext_req = 1'b0;
    waitAck(cyc);
    checkOutput("mix_ent_gap", cyc, 34);
    checkOutput("mix_ent_ack", 32'(ent_ack), 1);
    checkOutput("mix_ent_spot", 32'(ent_spot), 5);
    applyStimulus(2'b00, 7'h0, 7'h0, 1'b0, 7'h0);
    step();

    // Reset during scan cycle 10 aborts the entry with no ack.
    applyStimulus(2'b10, 7'h0, 7'h73, 1'b0, 7'h0);
    for (int i = 0; i < 10; i++) step();
    checkOutput("abort_busy_before", 32'(busy), 1);
    reset = 1'b1;
    step();
    checkOutput("abort_ack", 32'(ent_ack), 0);
    checkOutput("abort_status", {parq4_status, parq3_status, parq2_status, parq1_status}, 0);
    checkOutput("abort_free", 32'(free_count), 32);
    checkOutput("abort_busy", 32'(busy), 0);
    reset = 1'b0;
    applyStimulus(2'b00, 7'h0, 7'h0, 1'b0, 7'h0);
    for (int i = 0; i < 40; i++) step();
    checkOutput("abort_no_late_ack", 32'(ent_ack), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
